// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: font type, hex glyph table, blank pattern
// and the scan state encoding.
package seg7_pkg;

  // Active-low a..g glyph, bit 6 = segment a, bit 0 = segment g
  typedef logic [6:0] seg_font_t;

  // Scan slot phases: dead time with everything off, then the digit shown
  typedef enum logic {
    GUARD_S = 1'b0,
    SHOW_S  = 1'b1
  } scan_state_t;

  // Full segment bus with every segment and the decimal point dark
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Hex glyphs 0..F, active-low a..g
  localparam seg_font_t hex_font [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/seg7_scan_if.sv
// Display bus between a data source and the scan driver. The master supplies
// the word, decimal points and controls; the slave drives the board pins.
interface seg7_scan_if #(
  parameter int DIGITS = 8
);

  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic                en;
  logic                lz_blank;
  logic [DIGITS-1:0]   an;
  logic [7:0]          seg;
  logic                frame_start;

  modport master (
    output data, dp, en, lz_blank,
    input  an, seg, frame_start
  );

  modport slave (
    input  data, dp, en, lz_blank,
    output an, seg, frame_start
  );

endinterface

// File: rtl/seg7_font.sv
// Combinational hex nibble to active-low a..g glyph lookup, shared by the
// display blocks.
module seg7_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_font_t  font
);

  assign font = hex_font[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment scan driver. Each digit slot starts with GUARD
// dark cycles, then drives one anode low with that digit's glyph. The input
// word is captured once per frame so a digit never changes mid-frame.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 500,
  parameter int DIGITS  = 8,
  parameter int GUARD   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  bus
);

  localparam int DIV   = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  // With no dead time every slot opens directly in the show phase
  localparam scan_state_t INIT_S = (GUARD == 0) ? SHOW_S : GUARD_S;

  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [IDX_W-1:0]    idx, idx_nx;
  scan_state_t         state, state_nx;
  logic                en_q;
  logic                start, wrap, load;
  logic [4*DIGITS-1:0] data_snap, data_nx;
  logic [DIGITS-1:0]   dp_snap, dp_nx;
  logic                lz_snap, lz_nx;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          nib_sel;
  logic                dp_sel;
  logic                blank_sel;
  logic [DIGITS-1:0]   an_sel;
  seg_font_t           font_sel;
  logic [DIGITS-1:0]   an_nx;
  logic [7:0]          seg_nx;

  // Next counter, digit index, phase and snapshot; a rising enable restarts the frame
  always_comb begin
    start   = bus.en && !en_q;
    wrap    = en_q && (cnt == CNT_LAST) && (idx == IDX_LAST);
    load    = start || wrap;
    data_nx = load ? bus.data : data_snap;
    dp_nx   = load ? bus.dp : dp_snap;
    lz_nx   = load ? bus.lz_blank : lz_snap;

    state_nx = state;
    case (state)
      GUARD_S: if (cnt == GUARD_LAST) state_nx = SHOW_S;
      SHOW_S:  if ((cnt == CNT_LAST) && (GUARD != 0)) state_nx = GUARD_S;
      default: state_nx = INIT_S;
    endcase

    if (!bus.en || start) begin
      cnt_nx   = '0;
      idx_nx   = '0;
      state_nx = INIT_S;
    end else if (cnt == CNT_LAST) begin
      cnt_nx = '0;
      idx_nx = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt_nx = cnt + 1'b1;
      idx_nx = idx;
    end
  end

  // Leading-zero chain from the top digit down; it stops at the first digit that must show
  always_comb begin
    logic run;
    blank = '0;
    run   = lz_nx;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run      = run && (data_nx[4*i +: 4] == 4'h0) && !dp_nx[i];
      blank[i] = run;
    end
  end

  // Pick the nibble, decimal point, blank flag and anode of the digit in the next slot
  always_comb begin
    nib_sel   = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    an_sel    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nx == IDX_W'(i)) begin
        nib_sel   = data_nx[4*i +: 4];
        dp_sel    = dp_nx[i];
        blank_sel = blank[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  seg7_font u_font (
    .nibble (nib_sel),
    .font   (font_sel)
  );

  // Pin values for the next cycle: dark during dead time or when disabled
  always_comb begin
    an_nx  = '1;
    seg_nx = SEG_OFF;
    if (bus.en && (state_nx == SHOW_S)) begin
      an_nx = an_sel;
      if (!blank_sel) seg_nx = {font_sel, ~dp_sel};
    end
  end

  // Scan FSM, counters, snapshot and registered pin drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      idx             <= '0;
      state           <= INIT_S;
      en_q            <= 1'b0;
      data_snap       <= '0;
      dp_snap         <= '0;
      lz_snap         <= 1'b0;
      bus.an          <= '1;
      bus.seg         <= SEG_OFF;
      bus.frame_start <= 1'b0;
    end else begin
      cnt             <= cnt_nx;
      idx             <= idx_nx;
      state           <= state_nx;
      en_q            <= bus.en;
      data_snap       <= data_nx;
      dp_snap         <= dp_nx;
      lz_snap         <= lz_nx;
      bus.an          <= an_nx;
      bus.seg         <= seg_nx;
      bus.frame_start <= load;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan at reduced rate (DIGITS=4, DIV=5). One
// instance uses GUARD=1, a second uses GUARD=0 to show back-to-back slots.
module tb_seg7_scan;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  seg7_scan_if #(.DIGITS(4)) bus_g1 ();
  seg7_scan_if #(.DIGITS(4)) bus_g0 ();

  seg7_scan #(
    .CLK_HZ  (1000),
    .SCAN_HZ (50),
    .DIGITS  (4),
    .GUARD   (1)
  ) dut_g1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_g1)
  );

  seg7_scan #(
    .CLK_HZ  (1000),
    .SCAN_HZ (50),
    .DIGITS  (4),
    .GUARD   (0)
  ) dut_g0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_g0)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Anodes may never have more than one digit selected
  always @(negedge clk) begin
    compared = compared + 2;
    assert ($onehot0(~bus_g1.an)) else begin
      mismatched++;
      $error("[TB] FAIL onehot_g1: observed an=%b expected at most one low", bus_g1.an);
    end
    assert ($onehot0(~bus_g0.an)) else begin
      mismatched++;
      $error("[TB] FAIL onehot_g0: observed an=%b expected at most one low", bus_g0.an);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dp,
                               input logic en, input logic lz);
    bus_g1.data     = data;
    bus_g1.dp       = dp;
    bus_g1.en       = en;
    bus_g1.lz_blank = lz;
  endtask

  task automatic checkOutput(input string tag,
                             input logic [3:0] obs_an, input logic [7:0] obs_seg,
                             input logic obs_fs,
                             input logic [3:0] exp_an, input logic [7:0] exp_seg,
                             input logic exp_fs);
    compared = compared + 3;
    assert (obs_an === exp_an) else begin
      mismatched++;
      $error("[TB] FAIL %s an: observed %b expected %b", tag, obs_an, exp_an);
    end
    assert (obs_seg === exp_seg) else begin
      mismatched++;
      $error("[TB] FAIL %s seg: observed %h expected %h", tag, obs_seg, exp_seg);
    end
    assert (obs_fs === exp_fs) else begin
      mismatched++;
      $error("[TB] FAIL %s frame_start: observed %b expected %b", tag, obs_fs, exp_fs);
    end
  endtask

  // Walk one whole GUARD=1 frame from its snapshot cycle; leaves us on the next one
  task automatic checkFrame(input string tag, input logic [31:0] exp_segs);
    for (int d = 0; d < 4; d++) begin
      checkOutput($sformatf("%s d%0d guard", tag, d), bus_g1.an, bus_g1.seg,
                  bus_g1.frame_start, 4'hF, 8'hFF, d == 0);
      for (int k = 0; k < 4; k++) begin
        tick();
        checkOutput($sformatf("%s d%0d c%0d", tag, d, k), bus_g1.an, bus_g1.seg,
                    bus_g1.frame_start, ~(4'b0001 << d), exp_segs[8*d +: 8], 1'b0);
      end
      tick();
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    bus_g0.data     = 16'h9876;
    bus_g0.dp       = 4'b0000;
    bus_g0.en       = 1'b0;
    bus_g0.lz_blank = 1'b0;
    applyStimulus(16'h1234, 4'b0000, 1'b1, 1'b0);

    // Reset holds everything dark
    tick();
    tick();
    checkOutput("reset", bus_g1.an, bus_g1.seg, bus_g1.frame_start, 4'hF, 8'hFF, 1'b0);
    rst_n = 1'b1;
    tick();

    // Scan order and no tearing: the change lands after the snapshot
    applyStimulus(16'hABCD, 4'b0000, 1'b1, 1'b0);
    checkFrame("f1234", 32'h9F250D99);
    applyStimulus(16'h3210, 4'b0000, 1'b1, 1'b0);
    checkFrame("fABCD", 32'h11C16385);
    applyStimulus(16'h7654, 4'b0000, 1'b1, 1'b0);
    checkFrame("f3210", 32'h0D259F03);
    applyStimulus(16'hBA98, 4'b0000, 1'b1, 1'b0);
    checkFrame("f7654", 32'h1F414999);
    applyStimulus(16'hFEDC, 4'b0000, 1'b1, 1'b0);
    checkFrame("fBA98", 32'hC1110901);

    // Leading-zero blanking, then a decimal point stopping the chain
    applyStimulus(16'h0005, 4'b0000, 1'b1, 1'b1);
    checkFrame("fFEDC", 32'h71618563);
    applyStimulus(16'h0000, 4'b0000, 1'b1, 1'b1);
    checkFrame("lz0005", 32'hFFFFFF49);
    applyStimulus(16'h0000, 4'b0100, 1'b1, 1'b1);
    checkFrame("lz0000", 32'hFFFFFF03);
    checkFrame("lzdp", 32'hFF020303);

    // Disable mid-slot, then re-enable restarts at digit 0 with a fresh snapshot
    tick();
    tick();
    checkOutput("pre_dis", bus_g1.an, bus_g1.seg, bus_g1.frame_start, 4'b1110, 8'h03, 1'b0);
    applyStimulus(16'h0000, 4'b0100, 1'b0, 1'b1);
    tick();
    checkOutput("dis1", bus_g1.an, bus_g1.seg, bus_g1.frame_start, 4'hF, 8'hFF, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("dis4", bus_g1.an, bus_g1.seg, bus_g1.frame_start, 4'hF, 8'hFF, 1'b0);
    applyStimulus(16'h0000, 4'b0100, 1'b1, 1'b1);
    tick();
    checkFrame("reen", 32'hFF020303);

    // Asynchronous reset between edges blanks at once
    tick();
    tick();
    applyStimulus(16'h1234, 4'b0000, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", bus_g1.an, bus_g1.seg, bus_g1.frame_start, 4'hF, 8'hFF, 1'b0);
    tick();
    checkOutput("rst_hold", bus_g1.an, bus_g1.seg, bus_g1.frame_start, 4'hF, 8'hFF, 1'b0);
    rst_n = 1'b1;
    tick();
    checkFrame("post_rst", 32'h9F250D99);

    // GUARD=0: every cycle of the frame lights a digit
    bus_g0.en = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      checkOutput($sformatf("g0 c%0d", k), bus_g0.an, bus_g0.seg, bus_g0.frame_start,
                  ~(4'b0001 << (k / 5)), 8'(32'h09011F41 >> (8 * (k / 5))), k == 0);
      tick();
    end
    checkOutput("g0 wrap", bus_g0.an, bus_g0.seg, bus_g0.frame_start, 4'b1110, 8'h41, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
